// File: rtl/iq_demix.sv
// iq_demix: real-to-IQ demixer with an fs/4 local oscillator, followed by an
// integrate-and-dump decimator (factor 2^LOG2_DECIM) and a one-deep output
// holding register with valid/ready handshake.
//
// Ports:
//   clock      in   single rising-edge clock
//   reset      in   synchronous active-high reset
//   in_valid   in   demix_in carries a sample this cycle
//   demix_in   in   15-bit two's-complement real sample
//   lo_sync    in   restart LO phase and decimation frame (beats in_valid)
//   out_ready  in   downstream accepts i_o/q_o this cycle
//   out_valid  out  i_o/q_o hold an unconsumed result
//   i_o, q_o   out  15-bit two's-complement decimated I/Q results
//   lo_i_o     out  I LO code: 00 = 0, 01 = +1, 1x = -1
//   lo_q_o     out  Q LO code, same encoding
//   overrun    out  sticky: a completed result was dropped (reset clears)
module iq_demix #(
  parameter int unsigned LOG2_DECIM = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [14:0] demix_in,
  input  logic        lo_sync,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [14:0] i_o,
  output logic [14:0] q_o,
  output logic [1:0]  lo_i_o,
  output logic [1:0]  lo_q_o,
  output logic        overrun
);

  localparam int unsigned AccW = 15 + LOG2_DECIM;
  // DECIM-1 is all ones in a LOG2_DECIM-bit counter.
  localparam logic [LOG2_DECIM-1:0] CntLast = '1;

  logic [1:0]            phase_q, phase_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [AccW-1:0]       acc_i_q, acc_i_d;
  logic [AccW-1:0]       acc_q_q, acc_q_d;
  logic                  out_valid_q, out_valid_d;
  logic [14:0]           i_q, i_d;
  logic [14:0]           q_q, q_d;
  logic                  overrun_q, overrun_d;

  logic        accept;
  logic        frame_done;
  logic [14:0] neg_in;
  logic [14:0] term_i, term_q;
  logic [AccW-1:0] sum_i, sum_q;

  // LO codes decode straight from the phase register.
  always_comb begin
    lo_i_o = 2'b00;
    lo_q_o = 2'b00;
    unique case (phase_q)
      2'd0: lo_i_o = 2'b01;
      2'd1: lo_q_o = 2'b01;
      2'd2: lo_i_o = 2'b10;
      2'd3: lo_q_o = 2'b10;
      default: ;
    endcase
  end

  always_comb begin
    accept     = in_valid & ~lo_sync;
    frame_done = accept && (cnt_q == CntLast);

    // Negation saturates: -(-16384) is not representable in 15 bits.
    neg_in = (demix_in == 15'h4000) ? 15'h3fff : (~demix_in + 15'd1);

    term_i = 15'd0;
    term_q = 15'd0;
    unique case (phase_q)
      2'd0: term_i = demix_in;
      2'd1: term_q = demix_in;
      2'd2: term_i = neg_in;
      2'd3: term_q = neg_in;
      default: ;
    endcase

    sum_i = acc_i_q + {{LOG2_DECIM{term_i[14]}}, term_i};
    sum_q = acc_q_q + {{LOG2_DECIM{term_q[14]}}, term_q};
  end

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    q_d         = q_q;
    overrun_d   = overrun_q;

    if (lo_sync) begin
      phase_d = 2'd0;
      cnt_d   = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (accept) begin
      phase_d = phase_q + 2'd1;
      cnt_d   = cnt_q + 1'b1;
      if (frame_done) begin
        acc_i_d = '0;
        acc_q_d = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
    end

    if (frame_done) begin
      if (out_valid_q && !out_ready) begin
        // Old result still pending: keep it, drop the new one.
        overrun_d = 1'b1;
      end else begin
        // Floor shift by LOG2_DECIM, keeping the low 15 bits.
        i_d         = sum_i[LOG2_DECIM +: 15];
        q_d         = sum_q[LOG2_DECIM +: 15];
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= 2'd0;
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      out_valid_q <= 1'b0;
      i_q         <= 15'd0;
      q_q         <= 15'd0;
      overrun_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      q_q         <= q_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign i_o       = i_q;
  assign q_o       = q_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_iq_demix.sv
module tb_iq_demix;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [14:0] demix_in;
  logic        lo_sync;
  logic        out_ready;
  logic        out_valid;
  logic [14:0] i_o;
  logic [14:0] q_o;
  logic [1:0]  lo_i_o;
  logic [1:0]  lo_q_o;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  iq_demix #(.LOG2_DECIM(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .demix_in  (demix_in),
    .lo_sync   (lo_sync),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .i_o       (i_o),
    .q_o       (q_o),
    .lo_i_o    (lo_i_o),
    .lo_q_o    (lo_q_o),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic send(input logic [14:0] s);
    in_valid = 1'b1;
    demix_in = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  // Sends n samples repeating a,b,c,d; optional idle gaps between samples.
  task automatic send_pat(input logic [14:0] a, input logic [14:0] b, input logic [14:0] c,
                          input logic [14:0] d, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      case (k % 4)
        0: send(a);
        1: send(b);
        2: send(c);
        default: send(d);
      endcase
      if (gaps && (k % 3 == 1)) idle();
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    demix_in  = 15'd0;
    lo_sync   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_i", {1'b0, i_o}, 16'd0);
    chk("rst_q", {1'b0, q_o}, 16'd0);
    chk("rst_ovr", {15'd0, overrun}, 16'd0);
    chk("rst_lo_i", {14'd0, lo_i_o}, 16'd1);
    chk("rst_lo_q", {14'd0, lo_q_o}, 16'd0);
    reset = 1'b0;

    // Constant input cancels in both branches
    send(15'd1000);
    chk("lo_i_ph1", {14'd0, lo_i_o}, 16'd0);
    chk("lo_q_ph1", {14'd0, lo_q_o}, 16'd1);
    for (int k = 0; k < 14; k++) send(15'd1000);
    chk("no_early_valid", {15'd0, out_valid}, 16'd0);
    send(15'd1000);
    chk("dc_valid", {15'd0, out_valid}, 16'd1);
    chk("dc_i", {1'b0, i_o}, 16'd0);
    chk("dc_q", {1'b0, q_o}, 16'd0);
    idle();
    chk("dc_consumed", {15'd0, out_valid}, 16'd0);

    // fs/4 tones on I and on Q
    send_pat(15'd8000, 15'd0, -15'sd8000, 15'd0, 16, 1'b0);
    chk("toneI_i", {1'b0, i_o}, 16'd4000);
    chk("toneI_q", {1'b0, q_o}, 16'd0);
    send_pat(15'd0, 15'd8000, 15'd0, -15'sd8000, 16, 1'b0);
    chk("toneQ_i", {1'b0, i_o}, 16'd0);
    chk("toneQ_q", {1'b0, q_o}, 16'd4000);

    // Saturating negation of -16384
    send_pat(15'd0, 15'd0, 15'h4000, 15'd0, 16, 1'b0);
    chk("sat_i", {1'b0, i_o}, 16'd4095);
    chk("sat_q", {1'b0, q_o}, 16'd0);

    // Floor rounding: sum -4 >>> 4 = -1
    send_pat(15'h7fff, 15'd0, 15'd0, 15'd0, 16, 1'b0);
    chk("floor_i", {1'b0, i_o}, 16'h7fff);
    chk("floor_q", {1'b0, q_o}, 16'd0);
    chk("lo_wrap", {14'd0, lo_i_o}, 16'd1);

    // Simultaneous consume and load
    idle();
    out_ready = 1'b0;
    send_pat(15'd8000, 15'd0, -15'sd8000, 15'd0, 16, 1'b0);
    chk("hold_valid", {15'd0, out_valid}, 16'd1);
    send_pat(15'd0, 15'd8000, 15'd0, -15'sd8000, 15, 1'b0);
    chk("hold_stable_i", {1'b0, i_o}, 16'd4000);
    out_ready = 1'b1;
    send(-15'sd8000);
    chk("simul_valid", {15'd0, out_valid}, 16'd1);
    chk("simul_i", {1'b0, i_o}, 16'd0);
    chk("simul_q", {1'b0, q_o}, 16'd4000);
    chk("simul_ovr", {15'd0, overrun}, 16'd0);

    // Overrun: second result dropped while first is held
    idle();
    out_ready = 1'b0;
    send_pat(15'd8000, 15'd0, -15'sd8000, 15'd0, 16, 1'b0);
    chk("ovr_first_i", {1'b0, i_o}, 16'd4000);
    chk("ovr_first_flag", {15'd0, overrun}, 16'd0);
    send_pat(15'd0, 15'd8000, 15'd0, -15'sd8000, 16, 1'b0);
    chk("ovr_held_i", {1'b0, i_o}, 16'd4000);
    chk("ovr_held_q", {1'b0, q_o}, 16'd0);
    chk("ovr_flag", {15'd0, overrun}, 16'd1);
    out_ready = 1'b1;
    idle();
    chk("ovr_drain_valid", {15'd0, out_valid}, 16'd0);
    chk("ovr_drain_i", {1'b0, i_o}, 16'd4000);
    chk("ovr_sticky", {15'd0, overrun}, 16'd1);

    // lo_sync discards a partial frame and its own sample
    send_pat(15'd5000, 15'd5000, 15'd5000, 15'd5000, 7, 1'b1);
    lo_sync  = 1'b1;
    in_valid = 1'b1;
    demix_in = 15'd7777;
    tick();
    lo_sync  = 1'b0;
    in_valid = 1'b0;
    chk("sync_lo_i", {14'd0, lo_i_o}, 16'd1);
    chk("sync_lo_q", {14'd0, lo_q_o}, 16'd0);
    chk("sync_ovr_kept", {15'd0, overrun}, 16'd1);
    send_pat(15'd8000, 15'd0, -15'sd8000, 15'd0, 16, 1'b1);
    chk("sync_valid", {15'd0, out_valid}, 16'd1);
    chk("sync_i", {1'b0, i_o}, 16'd4000);
    chk("sync_q", {1'b0, q_o}, 16'd0);

    // Reset mid-frame with a pending result and sticky overrun
    out_ready = 1'b0;
    send_pat(15'd3000, 15'd3000, 15'd3000, 15'd3000, 9, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst_i", {1'b0, i_o}, 16'd0);
    chk("mid_rst_ovr", {15'd0, overrun}, 16'd0);
    chk("mid_rst_lo_i", {14'd0, lo_i_o}, 16'd1);
    send_pat(15'd0, 15'd8000, 15'd0, -15'sd8000, 16, 1'b0);
    chk("post_rst_valid", {15'd0, out_valid}, 16'd1);
    chk("post_rst_i", {1'b0, i_o}, 16'd0);
    chk("post_rst_q", {1'b0, q_o}, 16'd4000);
    chk("post_rst_ovr", {15'd0, overrun}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iq_demix.md
IQ_DEMIX -- requirements
Module: iq_demix

Interface
REQ-001 Parameter LOG2_DECIM, default 4, meaning log2 of the decimation factor DECIM (DECIM = 2^LOG2_DECIM, legal 1..8).
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  demix_in carries a sample this cycle.
REQ-005 demix_in  input  15  two's-complement real input sample.
REQ-006 lo_sync  input  1  restart LO phase and decimation frame.
REQ-007 out_ready  input  1  downstream accepts i_o/q_o this cycle.
REQ-008 out_valid  output  1  i_o/q_o hold an unconsumed result.
REQ-009 i_o  output  15  two's-complement in-phase decimated result.
REQ-010 q_o  output  15  two's-complement quadrature decimated result.
REQ-011 lo_i_o  output  2  current I LO code: 00 = 0, 01 = +1, 1x = -1.
REQ-012 lo_q_o  output  2  current Q LO code, same encoding.
REQ-013 overrun  output  1  sticky flag: a completed result was dropped.

Function
REQ-014 A 2-bit LO phase counter SHALL advance by one, modulo 4, on each accepted sample (in_valid=1, lo_sync=0), and hold otherwise.
REQ-015 LO codes per phase 0/1/2/3 SHALL be: lo_i_o = 01/00/10/00, lo_q_o = 00/01/00/10; both are combinational from the phase register.
REQ-016 Per accepted sample, I term = demix_in x LO_I and Q term = demix_in x LO_Q, where x(-1) saturates -16384 to +16383 and x0 gives 0.
REQ-017 Two signed accumulators of width 15+LOG2_DECIM SHALL sum the I and Q terms; no overflow is possible at this width.
REQ-018 A sample counter of width LOG2_DECIM SHALL count accepted samples, wrapping to 0 after DECIM-1.
REQ-019 On the edge accepting the DECIM-th sample of a frame, the full sums including that sample SHALL be arithmetically shifted right by LOG2_DECIM (floor) and the low 15 bits loaded into i_o/q_o; accumulators SHALL clear to 0 on that same edge.
REQ-020 Latency: the result is visible one cycle after the cycle presenting the frame's final sample.
REQ-021 out_valid SHALL set on a result load and clear on an edge where out_valid=1 and out_ready=1 with no new load.
REQ-022 Simultaneous consume and new load SHALL load the new result and keep out_valid=1.
REQ-023 If a result completes while out_valid=1 and out_ready=0, i_o/q_o SHALL keep the old result, the new result is discarded, and overrun SHALL set.
REQ-024 overrun SHALL be cleared only by reset.
REQ-025 lo_sync=1 SHALL take precedence over in_valid: phase, sample counter and accumulators clear to 0, and any sample in that cycle is discarded; out_valid, i_o, q_o and overrun are unaffected.
REQ-026 i_o/q_o SHALL remain stable while out_valid=1 except per REQ-022.

Reset
REQ-027 On reset=1 at an edge: phase, sample counter and accumulators = 0; out_valid = 0; i_o = q_o = 0; overrun = 0. Hence lo_i_o = 01 and lo_q_o = 00.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first accepted sample after reset uses phase 0 and starts a new frame.
REQ-029 Reset SHALL take precedence over lo_sync, in_valid and out_ready.

Verification
REQ-030 LOG2_DECIM=4, out_ready=1, 16 continuous samples of constant 1000 -> i_o=0, q_o=0, out_valid high for 1 cycle.
REQ-031 16 samples repeating +8000,0,-8000,0 from phase 0 -> i_o=4000, q_o=0; repeating 0,+8000,0,-8000 -> i_o=0, q_o=4000.
REQ-032 16 samples repeating 0,0,-16384,0 -> I terms +16383 (saturated) on phase 2, i_o = floor(4x16383/16) = 4095, q_o=0.
REQ-033 out_ready=0, two full frames of +8000,0,-8000,0 -> first result 4000 held, overrun=1 after the second frame; out_ready=1 then drops out_valid with i_o=4000.
REQ-034 Random in_valid gaps with lo_sync asserted after 7 samples -> those 7 are discarded, next result reflects only post-sync samples, lo_i_o=01 on the first post-sync sample.
REQ-035 Reset asserted after 9 samples of a frame -> all outputs 0 next cycle; the following 16 samples yield the correct result with no contribution from pre-reset samples.
